// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one status-less 8N1 UART transmitter among NUM_REQ byte producers.
// Grant one cycle after req; frame timer blocks new grants until the frame window ends.
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int BAUD_DIV = 10416,
    parameter int GUARD    = 2,
    localparam int FRAME_CYCLES = 10 * BAUD_DIV + GUARD,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int TW  = $clog2(FRAME_CYCLES) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id,
    output logic                   tx_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NUM_REQ);

    state_t               state_q;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       grant_q;
    logic [TW-1:0]        timer_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 tx_valid_q;
    logic [7:0]           data_q;
    logic                 busy_q;
    logic                 done_q;

    logic [IDW-1:0]       win_d;
    logic                 win_vld;
    logic [IDW-1:0]       ptr_d;
    logic [7:0]           req_byte [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_byte[g] = req_data[8*g +: 8];
    end

    // Scan downward from the farthest rotated position so the last hit is the one closest to ptr.
    always_comb begin : rr_pick
        logic [IDW:0] idx;
        idx     = '0;
        win_d   = '0;
        win_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (idx >= NREQ_W) begin
                idx = idx - NREQ_W;
            end
            if (req[idx[IDW-1:0]]) begin
                win_vld = 1'b1;
                win_d   = idx[IDW-1:0];
            end
        end
    end

    assign ptr_d = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            timer_q    <= '0;
            ack_q      <= '0;
            tx_valid_q <= 1'b0;
            data_q     <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            ack_q      <= '0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        data_q     <= req_byte[win_d];
                        grant_q    <= win_d;
                        tx_valid_q <= 1'b1;
                        ack_q      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_d;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    ptr_q   <= ptr_d;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Transmitter gives no status, so the window is timed from the start pulse.
                    if (timer_q == TW'(FRAME_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ack  = ack_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = data_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign tx_done  = done_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmitter (`valid`/`data` in, serial `dout` out, no busy/ready output) among NUM_REQ byte producers.
- Round-robin arbitration; issues a one-cycle `valid` pulse with the chosen byte to the transmitter.
- Tracks transmitter occupancy with an internal frame timer, since the transmitter reports no status.
- Sits between the application byte sources (key scanner, display echo, status reporter) and the UART transmit block at top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BAUD_DIV, 10416, clk cycles per UART bit; must match the transmitter's divider.
- GUARD, 2, extra idle cycles after each frame to absorb transmitter state-register and output-register latency.
- Derived, not overridable: FRAME_CYCLES = 10*BAUD_DIV + GUARD.
- Derived, not overridable: IDW = clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  per-requester request; held high until the matching ack
- req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i]; stable while req[i] is high
- req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted for transmission
- tx_valid  out  1  one-cycle start pulse to the transmitter
- tx_data  out  8  byte to the transmitter; valid while tx_valid is high, held afterwards
- busy  out  1  high in ISSUE and WAIT
- grant_id  out  IDW  index of the current/last granted requester
- tx_done  out  1  one-cycle pulse when the frame window ends

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, ptr=0, timer=0.
  - req_ack=0, tx_valid=0, tx_data=8'h00, busy=0, grant_id=0, tx_done=0.
- All outputs are registered.
- State IDLE:
  - If req != 0, select the first set bit searching from index ptr upward, wrapping modulo NUM_REQ.
  - On that edge: latch the winner's byte into tx_data, set grant_id = winner, go to ISSUE.
  - If req == 0, stay in IDLE.
- State ISSUE (exactly 1 cycle):
  - tx_valid=1, req_ack[grant_id]=1, busy=1.
  - Next edge: timer=0, ptr=(grant_id+1) mod NUM_REQ, go to WAIT.
- State WAIT:
  - timer increments each cycle.
  - When timer==FRAME_CYCLES-1: go to IDLE and pulse tx_done for the first IDLE cycle.
  - Requests are ignored during WAIT.
- Latency:
  - req[i] rises in IDLE at cycle t → tx_valid and req_ack[i] high in cycle t+1.
  - Earliest next tx_valid is FRAME_CYCLES+2 cycles after the previous tx_valid.
- Simultaneous requests: round-robin from ptr. Every requester is served within NUM_REQ frames (no starvation).
- A single persistent requester may be granted back-to-back if no other request is pending.
- req[i] dropped after the latch edge but before its ack: the byte is still transmitted and still acked. Requesters must not rely on withdrawal.
- req[i] high in the ack cycle is treated as a new request only if it is still high when the arbiter is next in IDLE.
- Requesters must drop req after the ack to avoid a duplicate send.
- timer width: clog2(FRAME_CYCLES)+1 bits; it never wraps, because it is cleared on ISSUE→WAIT.
- Reset mid-ISSUE or mid-WAIT: all state clears immediately, with no ack or tx_done pulse. The transmitter is reset by the same rst.
- Out-of-range ptr is impossible; the default case in the state decode returns to IDLE.

Test Plan:
- BAUD_DIV=4 (FRAME_CYCLES=42). Single request: req=4'b0100, data 8'hA5 → next cycle tx_valid=1, tx_data=A5, req_ack=4'b0100, grant_id=2. tx_done 43 cycles after tx_valid. Decoded serial line from the attached transmitter = A5.
- All four requests simultaneously after reset, bytes 11/22/33/44, each held until its ack → tx_valid order 11,22,33,44. tx_valid pulses exactly 44 cycles apart.
- req[1] held continuously, req[3] raised during the first frame → grants alternate 1,3,1. req[3] is never skipped.
- Request arrives in WAIT: req[0] asserted 10 cycles after tx_valid → no ack until the cycle after tx_done. Then tx_valid and ack follow on the next cycle.
- Assert rst for 1 cycle at timer=20 → busy=0, tx_valid=0, ptr=0. A pending req[2] is then granted 1 cycle after rst deasserts, with no tx_done from the aborted frame.
- Withdrawal: req[2] pulsed for exactly the latch cycle → byte still sent and req_ack[2] still pulses once. No second grant.
